// File: rtl/ex_mem_skid_stage_pkg.sv
// Shared EX/MEM definitions: control-bit layout and the skid stage state set.
package ex_mem_pkg;

    localparam int CTRL_W   = 4;
    localparam int REGWRITE = 0;
    localparam int MEMTOREG = 1;
    localparam int MEMREAD  = 2;
    localparam int MEMWRITE = 3;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    function automatic logic [1:0] occupancy_of(state_e s);
        case (s)
            ST_ONE:  return 2'd1;
            ST_FULL: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/ex_mem_skid_stage_if.sv
// EX->MEM handshake bundle; master drives the instruction side, slave is the stage.
interface ex_mem_skid_stage_if
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
);
    logic              flush_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [CTRL_W-1:0] ctrl_i;
    logic [DATA_W-1:0] alu_result_i;
    logic [DATA_W-1:0] rs2data_i;
    logic [ADDR_W-1:0] rdaddr_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [CTRL_W-1:0] ctrl_o;
    logic [DATA_W-1:0] alu_result_o;
    logic [DATA_W-1:0] rs2data_o;
    logic [ADDR_W-1:0] rdaddr_o;
    logic [1:0]        occupancy_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    modport master (
        output flush_i, in_valid_i, ctrl_i, alu_result_i, rs2data_i, rdaddr_i, out_ready_i,
        input  in_ready_o, out_valid_o, ctrl_o, alu_result_o, rs2data_o, rdaddr_o,
               occupancy_o, stall_cnt_o
    );

    modport slave (
        input  flush_i, in_valid_i, ctrl_i, alu_result_i, rs2data_i, rdaddr_i, out_ready_i,
        output in_ready_o, out_valid_o, ctrl_o, alu_result_o, rs2data_o, rdaddr_o,
               occupancy_o, stall_cnt_o
    );
endinterface

// File: rtl/ex_mem_skid_stage.sv
// Two-entry EX/MEM pipeline register with skid buffer; in_ready_o is decoded
// purely from the state register so it never sees out_ready_i combinationally.
module ex_mem_skid_stage
    import ex_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    ex_mem_skid_stage_if.slave  bus
);

    state_e            state_q;
    logic [CTRL_W-1:0] head_ctrl_q, skid_ctrl_q;
    logic [DATA_W-1:0] head_alu_q,  skid_alu_q;
    logic [DATA_W-1:0] head_rs2_q,  skid_rs2_q;
    logic [ADDR_W-1:0] head_rd_q,   skid_rd_q;
    logic [CNT_W-1:0]  stall_cnt_q;

    logic out_valid, in_ready, accept, drain, stall;

    assign out_valid = (state_q != ST_EMPTY);
    assign in_ready  = (state_q != ST_FULL);
    assign accept    = bus.in_valid_i & in_ready;
    assign drain     = out_valid & bus.out_ready_i;
    assign stall     = out_valid & ~bus.out_ready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            head_ctrl_q <= '0;
            head_alu_q  <= '0;
            head_rs2_q  <= '0;
            head_rd_q   <= '0;
            skid_ctrl_q <= '0;
            skid_alu_q  <= '0;
            skid_rs2_q  <= '0;
            skid_rd_q   <= '0;
            stall_cnt_q <= '0;
        end else begin
            // Back-pressure accounting is independent of flush.
            if (stall && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + 1'b1;

            if (bus.flush_i) begin
                state_q     <= ST_EMPTY;
                head_ctrl_q <= '0;
                skid_ctrl_q <= '0;
            end else begin
                case (state_q)
                    ST_EMPTY: begin
                        if (accept) begin
                            head_ctrl_q <= bus.ctrl_i;
                            head_alu_q  <= bus.alu_result_i;
                            head_rs2_q  <= bus.rs2data_i;
                            head_rd_q   <= bus.rdaddr_i;
                            state_q     <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (accept && drain) begin
                            head_ctrl_q <= bus.ctrl_i;
                            head_alu_q  <= bus.alu_result_i;
                            head_rs2_q  <= bus.rs2data_i;
                            head_rd_q   <= bus.rdaddr_i;
                        end else if (accept) begin
                            skid_ctrl_q <= bus.ctrl_i;
                            skid_alu_q  <= bus.alu_result_i;
                            skid_rs2_q  <= bus.rs2data_i;
                            skid_rd_q   <= bus.rdaddr_i;
                            state_q     <= ST_FULL;
                        end else if (drain) begin
                            state_q     <= ST_EMPTY;
                        end
                    end
                    ST_FULL: begin
                        if (drain) begin
                            head_ctrl_q <= skid_ctrl_q;
                            head_alu_q  <= skid_alu_q;
                            head_rs2_q  <= skid_rs2_q;
                            head_rd_q   <= skid_rd_q;
                            state_q     <= ST_ONE;
                        end
                    end
                    default: state_q <= ST_EMPTY;
                endcase
            end
        end
    end

    assign bus.out_valid_o  = out_valid;
    assign bus.in_ready_o   = in_ready;
    assign bus.occupancy_o  = occupancy_of(state_q);
    assign bus.ctrl_o       = out_valid ? head_ctrl_q : '0;
    assign bus.alu_result_o = head_alu_q;
    assign bus.rs2data_o    = head_rs2_q;
    assign bus.rdaddr_o     = head_rd_q;
    assign bus.stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_ex_mem_skid_stage.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_ex_mem_skid_stage;
    import ex_mem_pkg::*;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [4:0]  rd;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    ex_mem_skid_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) bus ();
    ex_mem_skid_stage_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(2))  bus2 ();

    ex_mem_skid_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus)
    );
    ex_mem_skid_stage #(.DATA_W(32), .ADDR_W(5), .CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .bus(bus2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] s, input logic [4:0] r);
        bus.in_valid_i   = v;
        bus.ctrl_i       = c;
        bus.alu_result_i = a;
        bus.rs2data_i    = s;
        bus.rdaddr_i     = r;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        bus.flush_i = 1'b0;  bus.out_ready_i = 1'b0;
        bus2.flush_i = 1'b0; bus2.out_ready_i = 1'b0; bus2.in_valid_i = 1'b0;
        bus2.ctrl_i = 4'h0; bus2.alu_result_i = 32'h0; bus2.rs2data_i = 32'h0; bus2.rdaddr_i = 5'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0b want=0", bus.out_valid_o); end
        checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL rst_ready got=%0b want=1", bus.in_ready_o); end
        checks++; if (bus.occupancy_o !== 2'd0) begin failures++; $display("FAIL rst_occ got=%0d want=0", bus.occupancy_o); end
        checks++; if (bus.ctrl_o !== 4'h0) begin failures++; $display("FAIL rst_ctrl got=%h want=0", bus.ctrl_o); end
        checks++; if (bus.alu_result_o !== 32'h0) begin failures++; $display("FAIL rst_alu got=%h want=0", bus.alu_result_o); end
        checks++; if (bus.rs2data_o !== 32'h0) begin failures++; $display("FAIL rst_rs2 got=%h want=0", bus.rs2data_o); end
        checks++; if (bus.rdaddr_o !== 5'd0) begin failures++; $display("FAIL rst_rd got=%0d want=0", bus.rdaddr_o); end
        checks++; if (bus.stall_cnt_o !== 16'd0) begin failures++; $display("FAIL rst_stall got=%0d want=0", bus.stall_cnt_o); end
        $display("test_reset done");
    endtask

    task automatic test_passthrough();
        logic [3:0] c = 4'h0;
        c[REGWRITE] = 1'b1;
        apply_reset();
        bus.out_ready_i = 1'b1;
        drive(1'b1, c, 32'h0000_00AA, 32'h1234_5678, 5'd5);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        checks++; if (bus.out_valid_o !== 1'b1) begin failures++; $display("FAIL pt_valid got=%0b want=1", bus.out_valid_o); end
        checks++; if (bus.ctrl_o !== 4'b0001) begin failures++; $display("FAIL pt_ctrl got=%b want=0001", bus.ctrl_o); end
        checks++; if (bus.alu_result_o !== 32'hAA) begin failures++; $display("FAIL pt_alu got=%h want=aa", bus.alu_result_o); end
        checks++; if (bus.rs2data_o !== 32'h1234_5678) begin failures++; $display("FAIL pt_rs2 got=%h want=12345678", bus.rs2data_o); end
        checks++; if (bus.rdaddr_o !== 5'd5) begin failures++; $display("FAIL pt_rd got=%0d want=5", bus.rdaddr_o); end
        checks++; if (bus.occupancy_o !== 2'd1) begin failures++; $display("FAIL pt_occ got=%0d want=1", bus.occupancy_o); end
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL pt_drained got=%0b want=0", bus.out_valid_o); end
        checks++; if (bus.ctrl_o !== 4'h0) begin failures++; $display("FAIL pt_bubble_ctrl got=%b want=0000", bus.ctrl_o); end
        checks++; if (bus.alu_result_o !== 32'hAA) begin failures++; $display("FAIL pt_hold_alu got=%h want=aa", bus.alu_result_o); end
        $display("test_passthrough done");
    endtask

    task automatic test_backpressure();
        logic [3:0] ca = 4'h0;
        logic [3:0] cb = 4'h0;
        ca[REGWRITE] = 1'b1; ca[MEMTOREG] = 1'b1; ca[MEMREAD] = 1'b1;
        cb[MEMWRITE] = 1'b1;
        apply_reset();
        bus.out_ready_i = 1'b0;
        drive(1'b1, ca, 32'h1, 32'hA1, 5'd1);
        tick();
        drive(1'b1, cb, 32'h2, 32'hB2, 5'd2);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        checks++; if (bus.occupancy_o !== 2'd2) begin failures++; $display("FAIL bp_occ got=%0d want=2", bus.occupancy_o); end
        checks++; if (bus.in_ready_o !== 1'b0) begin failures++; $display("FAIL bp_ready got=%0b want=0", bus.in_ready_o); end
        checks++; if (bus.alu_result_o !== 32'h1) begin failures++; $display("FAIL bp_headA got=%h want=1", bus.alu_result_o); end
        checks++; if (bus.ctrl_o !== ca) begin failures++; $display("FAIL bp_ctrlA got=%b want=%b", bus.ctrl_o, ca); end
        // One more held cycle in FULL: stalls were counted in ONE and now FULL.
        tick();
        checks++; if (bus.stall_cnt_o !== 16'd2) begin failures++; $display("FAIL bp_stall got=%0d want=2", bus.stall_cnt_o); end
        bus.out_ready_i = 1'b1;
        tick();
        checks++; if (bus.alu_result_o !== 32'h2) begin failures++; $display("FAIL bp_headB got=%h want=2", bus.alu_result_o); end
        checks++; if (bus.ctrl_o !== cb) begin failures++; $display("FAIL bp_ctrlB got=%b want=%b", bus.ctrl_o, cb); end
        checks++; if (bus.occupancy_o !== 2'd1) begin failures++; $display("FAIL bp_occ1 got=%0d want=1", bus.occupancy_o); end
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL bp_empty got=%0b want=0", bus.out_valid_o); end
        checks++; if (bus.stall_cnt_o !== 16'd2) begin failures++; $display("FAIL bp_stall_end got=%0d want=2", bus.stall_cnt_o); end
        $display("test_backpressure done");
    endtask

    task automatic test_flush();
        apply_reset();
        bus.out_ready_i = 1'b0;
        drive(1'b1, 4'b1000, 32'h11, 32'h0, 5'd3);
        tick();
        drive(1'b1, 4'b0100, 32'h22, 32'h0, 5'd4);
        tick();
        bus.flush_i = 1'b1;
        drive(1'b1, 4'b1111, 32'h33, 32'h0, 5'd6);
        tick();
        bus.flush_i = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        checks++; if (bus.occupancy_o !== 2'd0) begin failures++; $display("FAIL fl_occ got=%0d want=0", bus.occupancy_o); end
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL fl_valid got=%0b want=0", bus.out_valid_o); end
        checks++; if (bus.ctrl_o !== 4'h0) begin failures++; $display("FAIL fl_ctrl got=%b want=0000", bus.ctrl_o); end
        checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL fl_ready got=%0b want=1", bus.in_ready_o); end
        checks++; if (bus.stall_cnt_o !== 16'd2) begin failures++; $display("FAIL fl_stall got=%0d want=2", bus.stall_cnt_o); end
        bus.out_ready_i = 1'b1;
        drive(1'b1, 4'b0001, 32'h44, 32'h0, 5'd9);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        checks++; if (bus.alu_result_o !== 32'h44) begin failures++; $display("FAIL fl_next_alu got=%h want=44", bus.alu_result_o); end
        checks++; if (bus.occupancy_o !== 2'd1) begin failures++; $display("FAIL fl_next_occ got=%0d want=1", bus.occupancy_o); end
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL fl_no_dup got=%0b want=0", bus.out_valid_o); end
        $display("test_flush done");
    endtask

    task automatic test_async_reset();
        apply_reset();
        bus.out_ready_i = 1'b0;
        drive(1'b1, 4'b0111, 32'h55, 32'h5A, 5'd7);
        tick();
        drive(1'b1, 4'b0011, 32'h66, 32'h6A, 5'd8);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL ar_valid got=%0b want=0", bus.out_valid_o); end
        checks++; if (bus.occupancy_o !== 2'd0) begin failures++; $display("FAIL ar_occ got=%0d want=0", bus.occupancy_o); end
        checks++; if (bus.in_ready_o !== 1'b1) begin failures++; $display("FAIL ar_ready got=%0b want=1", bus.in_ready_o); end
        checks++; if (bus.ctrl_o !== 4'h0) begin failures++; $display("FAIL ar_ctrl got=%b want=0", bus.ctrl_o); end
        checks++; if (bus.alu_result_o !== 32'h0) begin failures++; $display("FAIL ar_alu got=%h want=0", bus.alu_result_o); end
        checks++; if (bus.rs2data_o !== 32'h0) begin failures++; $display("FAIL ar_rs2 got=%h want=0", bus.rs2data_o); end
        checks++; if (bus.rdaddr_o !== 5'd0) begin failures++; $display("FAIL ar_rd got=%0d want=0", bus.rdaddr_o); end
        checks++; if (bus.stall_cnt_o !== 16'd0) begin failures++; $display("FAIL ar_stall got=%0d want=0", bus.stall_cnt_o); end
        #1 rst = 1'b0;
        bus.out_ready_i = 1'b1;
        drive(1'b1, 4'b0001, 32'h77, 32'h7A, 5'd10);
        tick();
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        checks++; if (bus.occupancy_o !== 2'd1) begin failures++; $display("FAIL ar_after_occ got=%0d want=1", bus.occupancy_o); end
        checks++; if (bus.alu_result_o !== 32'h77) begin failures++; $display("FAIL ar_after_alu got=%h want=77", bus.alu_result_o); end
        tick();
        checks++; if (bus.out_valid_o !== 1'b0) begin failures++; $display("FAIL ar_after_empty got=%0b want=0", bus.out_valid_o); end
        $display("test_async_reset done");
    endtask

    task automatic test_saturation();
        apply_reset();
        bus2.out_ready_i = 1'b0;
        bus2.in_valid_i  = 1'b1;
        bus2.alu_result_i = 32'hC0FFEE;
        bus2.ctrl_i = 4'b0001;
        tick();
        bus2.in_valid_i = 1'b0;
        checks++; if (bus2.stall_cnt_o !== 2'd0) begin failures++; $display("FAIL sat_start got=%0d want=0", bus2.stall_cnt_o); end
        for (int k = 1; k <= 5; k++) begin
            tick();
            checks++; if (bus2.out_valid_o !== 1'b1) begin failures++; $display("FAIL sat_valid cyc=%0d got=%0b want=1", k, bus2.out_valid_o); end
            checks++; if (int'(bus2.stall_cnt_o) != ((k < 3) ? k : 3)) begin failures++; $display("FAIL sat_cnt cyc=%0d got=%0d want=%0d", k, bus2.stall_cnt_o, (k < 3) ? k : 3); end
        end
        $display("test_saturation done");
    endtask

    task automatic test_random();
        ent_t q[$];
        ent_t e;
        int   stall_m = 0;
        int   delivered = 0;
        int   cycles = 0;
        logic fl, acc, drn, ir;
        apply_reset();
        while (delivered < 1000 && cycles < 20000) begin
            cycles++;
            e.ctrl = 4'($urandom); e.alu = $urandom; e.rs2 = $urandom; e.rd = 5'($urandom);
            bus.flush_i     = ($urandom_range(0, 79) == 0);
            bus.out_ready_i = ($urandom_range(0, 99) < 60);
            drive($urandom_range(0, 99) < 70, e.ctrl, e.alu, e.rs2, e.rd);
            #1;
            checks++; if (bus.out_valid_o !== (q.size() > 0)) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%0b want=%0b", cycles, bus.out_valid_o, q.size() > 0); end
            checks++; if (bus.in_ready_o !== (q.size() < 2)) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%0b want=%0b", cycles, bus.in_ready_o, q.size() < 2); end
            checks++; if (int'(bus.occupancy_o) != q.size()) begin failures++; $display("FAIL rnd_occ cyc=%0d got=%0d want=%0d", cycles, bus.occupancy_o, q.size()); end
            checks++; if (int'(bus.stall_cnt_o) != stall_m) begin failures++; $display("FAIL rnd_stall cyc=%0d got=%0d want=%0d", cycles, bus.stall_cnt_o, stall_m); end
            if (q.size() > 0) begin
                checks++;
                if ({bus.ctrl_o, bus.alu_result_o, bus.rs2data_o, bus.rdaddr_o} !== q[0]) begin
                    failures++;
                    $display("FAIL rnd_head cyc=%0d got=%h/%h/%h/%0d want=%h/%h/%h/%0d", cycles,
                             bus.ctrl_o, bus.alu_result_o, bus.rs2data_o, bus.rdaddr_o,
                             q[0].ctrl, q[0].alu, q[0].rs2, q[0].rd);
                end
            end else begin
                checks++; if (bus.ctrl_o !== 4'h0) begin failures++; $display("FAIL rnd_bubble cyc=%0d got=%b want=0000", cycles, bus.ctrl_o); end
            end
            // Wiggle out_ready_i mid-cycle: in_ready_o must not follow it.
            ir = bus.in_ready_o;
            bus.out_ready_i = ~bus.out_ready_i;
            #1;
            checks++; if (bus.in_ready_o !== ir) begin failures++; $display("FAIL rnd_comb_path cyc=%0d got=%0b want=%0b", cycles, bus.in_ready_o, ir); end
            bus.out_ready_i = ~bus.out_ready_i;
            #1;
            fl  = bus.flush_i;
            acc = bus.in_valid_i && (q.size() < 2);
            drn = (q.size() > 0) && bus.out_ready_i;
            if ((q.size() > 0) && !bus.out_ready_i && stall_m < 65535) stall_m++;
            if (fl) begin
                q.delete();
            end else begin
                if (drn) begin void'(q.pop_front()); delivered++; end
                if (acc) q.push_back(e);
            end
            tick();
        end
        checks++; if (delivered < 1000) begin failures++; $display("FAIL rnd_budget delivered=%0d want=1000", delivered); end
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        bus.flush_i = 1'b0;
        $display("test_random done delivered=%0d cycles=%0d", delivered, cycles);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.flush_i = 1'b0;
        bus.out_ready_i = 1'b0;
        drive(1'b0, 4'h0, 32'h0, 32'h0, 5'd0);
        test_reset();
        test_passthrough();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
